// File: rtl/space_invaders_pkg.sv
// Shared Space Invaders definitions: screen geometry, colour codes and the
// alien fleet state/direction encodings.
package space_invaders_pkg;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int SHIP_WIDTH    = 32;
  localparam int SHIP_HEIGHT   = 16;
  localparam int V_OFFSET      = 24;

  localparam logic [2:0] BACKGROUND = 3'd0;
  localparam logic [2:0] ALIEN      = 3'd3;
  localparam logic [2:0] LASER      = 3'd6;

  typedef enum logic [1:0] {MARCH, DROP, HALT} fleet_state_t;
  typedef enum logic {DIR_RIGHT, DIR_LEFT} fleet_dir_t;

endpackage

// File: rtl/alien_grid_locator.sv
// Maps a screen point onto the alien grid: cell row/col and whether the point
// falls on the alien sprite (not the gap) of an in-range cell.
module alien_grid_locator #(
  parameter int ROWS    = 4,
  parameter int COLS    = 8,
  parameter int ALIEN_W = 24,
  parameter int ALIEN_H = 16,
  parameter int PITCH_X = 32,
  parameter int PITCH_Y = 32,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic [9:0]    i_x,
  input  logic [9:0]    i_y,
  input  logic [9:0]    i_org_x,
  input  logic [9:0]    i_org_y,
  output logic [RW-1:0] o_row,
  output logic [CW-1:0] o_col,
  output logic          o_inside
);
  localparam int PX_SH = $clog2(PITCH_X);
  localparam int PY_SH = $clog2(PITCH_Y);

  logic [9:0] w_rel_x, w_rel_y, w_col_full, w_row_full, w_off_x, w_off_y;

  assign w_rel_x    = i_x - i_org_x;
  assign w_rel_y    = i_y - i_org_y;
  assign w_col_full = w_rel_x >> PX_SH;
  assign w_row_full = w_rel_y >> PY_SH;
  assign w_off_x    = w_rel_x & 10'(PITCH_X - 1);
  assign w_off_y    = w_rel_y & 10'(PITCH_Y - 1);

  // Point left of / above the origin wraps in the subtract, so reject it first.
  assign o_inside = (i_x >= i_org_x) && (i_y >= i_org_y) &&
                    (w_col_full < 10'(COLS)) && (w_row_full < 10'(ROWS)) &&
                    (w_off_x < 10'(ALIEN_W)) && (w_off_y < 10'(ALIEN_H));

  assign o_row = w_row_full[RW-1:0];
  assign o_col = w_col_full[CW-1:0];

endmodule

// File: rtl/alien_fleet.sv
// Alien fleet controller: alive mask, march/drop movement, laser hit
// detection, alien pixel colour and cleared/landed end conditions.
module alien_fleet
  import space_invaders_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 8,
  parameter int ALIEN_W  = 24,
  parameter int ALIEN_H  = 16,
  parameter int PITCH_X  = 32,
  parameter int PITCH_Y  = 32,
  parameter int START_X  = 64,
  parameter int START_Y  = 40,
  parameter int STEP_X   = 2,
  parameter int STEP_Y   = 16,
  parameter int MOVE_DIV = 4,
  parameter int LAND_Y   = SCREEN_HEIGHT - V_OFFSET - SHIP_HEIGHT,
  localparam int CNT_W   = $clog2(ROWS*COLS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [9:0]       xLaser,
  input  logic [9:0]       yLaser,
  input  logic [9:0]       hPos,
  input  logic [9:0]       vPos,
  output logic             killingAlien,
  output logic [2:0]       colorAlien,
  output logic [CNT_W-1:0] aliveCount,
  output logic [9:0]       fleetX,
  output logic [9:0]       fleetY,
  output logic             fleetCleared,
  output logic             fleetLanded
);
  localparam int N     = ROWS * COLS;
  localparam int IW    = (N > 1) ? $clog2(N) : 1;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int MW    = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int PX_SH = $clog2(PITCH_X);
  localparam int PY_SH = $clog2(PITCH_Y);
  localparam int EW    = 12;

  fleet_state_t     r_state, w_state_nx;
  fleet_dir_t       r_dir, w_dir_nx;
  logic [N-1:0]     r_mask;
  logic [CNT_W-1:0] r_alive_cnt;
  logic [9:0]       r_fx, r_fy, w_fx_nx, w_fy_nx;
  logic [MW-1:0]    r_move_cnt;
  logic             r_kill, r_cleared, r_landed;
  logic [2:0]       r_color;

  logic [RW-1:0]    w_l_row, w_p_row, w_rmax;
  logic [CW-1:0]    w_l_col, w_p_col, w_cmin, w_cmax;
  logic             w_l_in, w_p_in;
  logic [IW-1:0]    w_l_idx, w_p_idx;
  logic [COLS-1:0]  w_col_live;
  logic [ROWS-1:0]  w_row_live;
  logic             w_tick, w_parked, w_hit, w_right_edge, w_left_edge, w_land, w_halt;

  alien_grid_locator #(
    .ROWS(ROWS), .COLS(COLS), .ALIEN_W(ALIEN_W), .ALIEN_H(ALIEN_H),
    .PITCH_X(PITCH_X), .PITCH_Y(PITCH_Y)
  ) u_loc_laser (
    .i_x(xLaser), .i_y(yLaser), .i_org_x(r_fx), .i_org_y(r_fy),
    .o_row(w_l_row), .o_col(w_l_col), .o_inside(w_l_in)
  );

  alien_grid_locator #(
    .ROWS(ROWS), .COLS(COLS), .ALIEN_W(ALIEN_W), .ALIEN_H(ALIEN_H),
    .PITCH_X(PITCH_X), .PITCH_Y(PITCH_Y)
  ) u_loc_pixel (
    .i_x(hPos), .i_y(vPos), .i_org_x(r_fx), .i_org_y(r_fy),
    .o_row(w_p_row), .o_col(w_p_col), .o_inside(w_p_in)
  );

  assign w_l_idx  = IW'(w_l_row) * IW'(COLS) + IW'(w_l_col);
  assign w_p_idx  = IW'(w_p_row) * IW'(COLS) + IW'(w_p_col);
  assign w_parked = (xLaser == 10'(SCREEN_WIDTH - 1)) && (yLaser == 10'(SCREEN_HEIGHT - 1));
  assign w_hit    = (r_state != HALT) && !r_kill && !w_parked && w_l_in && r_mask[w_l_idx];

  always_comb begin
    w_col_live = '0;
    w_row_live = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (r_mask[r*COLS + c]) begin
          w_col_live[c] = 1'b1;
          w_row_live[r] = 1'b1;
        end
  end

  // Priority encoders; values are don't-care when the mask is empty.
  always_comb begin
    w_cmin = '0;
    w_cmax = '0;
    w_rmax = '0;
    for (int c = COLS - 1; c >= 0; c--) if (w_col_live[c]) w_cmin = CW'(c);
    for (int c = 0; c < COLS; c++)      if (w_col_live[c]) w_cmax = CW'(c);
    for (int r = 0; r < ROWS; r++)      if (w_row_live[r]) w_rmax = RW'(r);
  end

  assign w_right_edge = (EW'(r_fx) + (EW'(w_cmax) << PX_SH) + EW'(ALIEN_W - 1 + STEP_X))
                        > EW'(SCREEN_WIDTH - 1);
  assign w_left_edge  = (EW'(r_fx) + (EW'(w_cmin) << PX_SH)) < EW'(STEP_X);
  assign w_land       = (|r_mask) &&
                        ((EW'(r_fy) + (EW'(w_rmax) << PY_SH) + EW'(ALIEN_H - 1)) >= EW'(LAND_Y));
  assign w_halt       = (r_alive_cnt == '0) || w_land;
  assign w_tick       = enable && (r_move_cnt == MW'(MOVE_DIV - 1));

  always_comb begin
    w_state_nx = r_state;
    w_dir_nx   = r_dir;
    w_fx_nx    = r_fx;
    w_fy_nx    = r_fy;
    if (w_halt) begin
      w_state_nx = HALT;
    end else begin
      case (r_state)
        MARCH: if (w_tick) begin
          if (r_dir == DIR_RIGHT) begin
            if (w_right_edge) w_state_nx = DROP;
            else              w_fx_nx = r_fx + 10'(STEP_X);
          end else begin
            if (w_left_edge)  w_state_nx = DROP;
            else              w_fx_nx = r_fx - 10'(STEP_X);
          end
        end
        DROP: if (w_tick) begin
          w_fy_nx    = r_fy + 10'(STEP_Y);
          w_dir_nx   = (r_dir == DIR_RIGHT) ? DIR_LEFT : DIR_RIGHT;
          w_state_nx = MARCH;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= MARCH;
      r_dir   <= DIR_RIGHT;
      r_fx    <= 10'(START_X);
      r_fy    <= 10'(START_Y);
    end else begin
      r_state <= w_state_nx;
      r_dir   <= w_dir_nx;
      r_fx    <= w_fx_nx;
      r_fy    <= w_fy_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask      <= '1;
      r_alive_cnt <= CNT_W'(N);
      r_move_cnt  <= '0;
      r_kill      <= 1'b0;
      r_color     <= BACKGROUND;
      r_cleared   <= 1'b0;
      r_landed    <= 1'b0;
    end else begin
      // Hold the hit until the laser has seen it on an enable cycle.
      if (w_hit) begin
        r_mask[w_l_idx] <= 1'b0;
        r_alive_cnt     <= r_alive_cnt - CNT_W'(1);
        r_kill          <= 1'b1;
      end else if (r_kill && enable) begin
        r_kill <= 1'b0;
      end
      if (enable && r_state != HALT)
        r_move_cnt <= w_tick ? '0 : r_move_cnt + MW'(1);
      r_color   <= (w_p_in && r_mask[w_p_idx]) ? ALIEN : BACKGROUND;
      r_cleared <= r_cleared | (r_alive_cnt == '0);
      r_landed  <= r_landed | w_land;
    end
  end

  assign killingAlien = r_kill;
  assign colorAlien   = r_color;
  assign aliveCount   = r_alive_cnt;
  assign fleetX       = r_fx;
  assign fleetY       = r_fy;
  assign fleetCleared = r_cleared;
  assign fleetLanded  = r_landed;

endmodule

// File: tb/tb_alien_fleet.sv
// Bench for alien_fleet: rectangle-based fleet model checked every cycle,
// plus literal checkpoints for reset, march, hits, edges and end conditions.
module tb_alien_fleet;
  localparam int ROWS = 4, COLS = 8, AW = 24, AH = 16, PX = 32, PY = 32;
  localparam int STEP_X = 2, STEP_Y = 16, MOVE_DIV = 4, LAND_Y = 440;
  localparam int SW = 640, PARK_X = 639, PARK_Y = 479;

  logic       clk = 1'b0, reset = 1'b1, enable = 1'b0;
  logic [9:0] xLaser = 10'd639, yLaser = 10'd479, hPos = '0, vPos = '0;
  logic       killingAlien, fleetCleared, fleetLanded;
  logic [2:0] colorAlien;
  logic [5:0] aliveCount;
  logic [9:0] fleetX, fleetY;

  alien_fleet dut (
    .clk(clk), .reset(reset), .enable(enable), .xLaser(xLaser), .yLaser(yLaser),
    .hPos(hPos), .vPos(vPos), .killingAlien(killingAlien), .colorAlien(colorAlien),
    .aliveCount(aliveCount), .fleetX(fleetX), .fleetY(fleetY),
    .fleetCleared(fleetCleared), .fleetLanded(fleetLanded)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  bit armed = 0;

  // Model: screen-space rectangles, phase 0=march 1=drop 2=halt, dir +1/-1.
  bit m_alive [ROWS][COLS];
  int m_fx, m_fy, m_dir, m_phase, m_pulses, m_cnt;
  bit m_kill, m_cleared, m_landed;
  int m_color;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit find(input int px, input int py, output int fr, output int fc);
    fr = 0; fc = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (m_alive[r][c] && px >= m_fx + c*PX && px < m_fx + c*PX + AW &&
            py >= m_fy + r*PY && py < m_fy + r*PY + AH) begin
          fr = r; fc = c;
          return 1'b1;
        end
    return 1'b0;
  endfunction

  task automatic model_step();
    int hr, hc, pr, pc, left, right;
    bit hit, land_c, halting, tick;
    if (reset) begin
      foreach (m_alive[r, c]) m_alive[r][c] = 1'b1;
      m_fx = 64; m_fy = 40; m_dir = 1; m_phase = 0; m_pulses = 0; m_cnt = ROWS*COLS;
      m_kill = 0; m_cleared = 0; m_landed = 0; m_color = 0;
      return;
    end
    land_c = 0; left = 100000; right = -1;
    foreach (m_alive[r, c]) if (m_alive[r][c]) begin
      if (m_fy + r*PY + AH - 1 >= LAND_Y) land_c = 1;
      if (m_fx + c*PX < left) left = m_fx + c*PX;
      if (m_fx + c*PX + AW - 1 > right) right = m_fx + c*PX + AW - 1;
    end
    halting = (m_cnt == 0) || land_c;
    hit = 0;
    if (m_phase != 2 && !m_kill && !(xLaser == 10'(PARK_X) && yLaser == 10'(PARK_Y)))
      hit = find(int'(xLaser), int'(yLaser), hr, hc);
    m_color = find(int'(hPos), int'(vPos), pr, pc) ? 3 : 0;
    tick = enable && m_phase != 2 && (m_pulses % MOVE_DIV == MOVE_DIV - 1);
    if (enable && m_phase != 2) m_pulses++;
    if (m_cnt == 0) m_cleared = 1;
    if (land_c) m_landed = 1;
    if (halting) m_phase = 2;
    else if (tick) begin
      if (m_phase == 0) begin
        if (m_dir > 0) begin
          if (right + STEP_X > SW - 1) m_phase = 1; else m_fx += STEP_X;
        end else begin
          if (left < STEP_X) m_phase = 1; else m_fx -= STEP_X;
        end
      end else begin
        m_fy += STEP_Y; m_dir = -m_dir; m_phase = 0;
      end
    end
    if (hit) begin
      m_alive[hr][hc] = 0; m_cnt--; m_kill = 1;
    end else if (m_kill && enable) m_kill = 0;
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) if (armed) begin
    chk("kill", int'(killingAlien), int'(m_kill));
    chk("color", int'(colorAlien), m_color);
    chk("count", int'(aliveCount), m_cnt);
    chk("fleetX", int'(fleetX), m_fx);
    chk("fleetY", int'(fleetY), m_fy);
    chk("cleared", int'(fleetCleared), int'(m_cleared));
    chk("landed", int'(fleetLanded), int'(m_landed));
  end

  task automatic drive(input bit en, input int xl, input int yl);
    @(negedge clk); #1;
    enable = en; xLaser = 10'(xl); yLaser = 10'(yl);
    hPos = 10'($urandom_range(0, 639)); vPos = 10'($urandom_range(0, 479));
  endtask

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : (v > hi) ? hi : v;
  endfunction

  initial begin
    int saved;
    @(negedge clk); armed = 1;
    @(negedge clk); #1; reset = 0;
    chk("rst_count", int'(aliveCount), 32);
    chk("rst_fx", int'(fleetX), 64);
    chk("rst_fy", int'(fleetY), 40);
    chk("rst_kill", int'(killingAlien), 0);
    chk("rst_color", int'(colorAlien), 0);

    drive(0, PARK_X, PARK_Y); hPos = 10'd70; vPos = 10'd45;
    drive(0, PARK_X, PARK_Y);
    chk("pix_color", int'(colorAlien), 3);

    drive(0, 90, 45);
    drive(0, PARK_X, PARK_Y);
    chk("gap_miss", int'(killingAlien), 0);
    drive(0, PARK_X, PARK_Y);
    chk("park_miss", int'(aliveCount), 32);

    repeat (4) drive(1, PARK_X, PARK_Y);
    drive(0, PARK_X, PARK_Y);
    chk("march4", int'(fleetX), 66);
    repeat (4) drive(1, PARK_X, PARK_Y);
    drive(0, PARK_X, PARK_Y);
    chk("march8", int'(fleetX), 68);

    drive(0, PARK_X, PARK_Y); xLaser = 10'd69; yLaser = 10'd45;
    drive(0, PARK_X, PARK_Y);
    chk("hit_kill", int'(killingAlien), 1);
    chk("hit_count", int'(aliveCount), 31);
    chk("mdl_bit0", int'(m_alive[0][0]), 0);
    drive(1, PARK_X, PARK_Y);
    chk("kill_hold", int'(killingAlien), 1);
    drive(0, PARK_X, PARK_Y);
    chk("kill_drop", int'(killingAlien), 0);
    xLaser = 10'd69; yLaser = 10'd45;
    drive(0, PARK_X, PARK_Y);
    chk("repeat_miss", int'(killingAlien), 0);
    chk("repeat_count", int'(aliveCount), 31);

    // Walk to the right edge; sample only after the enable has been consumed.
    for (int i = 0; i < 2000 && m_fx != 392; i++) begin
      drive(1, PARK_X, PARK_Y);
      drive(0, PARK_X, PARK_Y);
    end
    chk("edge_fx", int'(fleetX), 392);
    repeat (4) drive(1, PARK_X, PARK_Y);
    drive(0, PARK_X, PARK_Y);
    chk("drop_fx", int'(fleetX), 392);
    chk("drop_fy", int'(fleetY), 40);
    repeat (4) drive(1, PARK_X, PARK_Y);
    drive(0, PARK_X, PARK_Y);
    chk("dropped_fy", int'(fleetY), 56);
    chk("dropped_fx", int'(fleetX), 392);
    repeat (4) drive(1, PARK_X, PARK_Y);
    drive(0, PARK_X, PARK_Y);
    chk("left_fx", int'(fleetX), 390);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0)
        drive($urandom_range(0, 1) == 1, clampi(m_fx - 4 + int'($urandom_range(0, 270)), 639),
              clampi(m_fy - 4 + int'($urandom_range(0, 130)), 479));
      else
        drive($urandom_range(0, 1) == 1, PARK_X, PARK_Y);
    end

    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (m_alive[r][c]) begin
          drive(0, PARK_X, PARK_Y);
          xLaser = 10'(m_fx + c*PX + 12); yLaser = 10'(m_fy + r*PY + 8);
          drive(1, PARK_X, PARK_Y);
        end
    drive(0, PARK_X, PARK_Y);
    drive(0, PARK_X, PARK_Y);
    chk("clr_count", int'(aliveCount), 0);
    chk("clr_flag", int'(fleetCleared), 1);
    saved = m_fx;
    repeat (8) drive(1, PARK_X, PARK_Y);
    drive(0, PARK_X, PARK_Y);
    chk("clr_frozen", int'(fleetX), saved);

    reset = 1;
    drive(0, PARK_X, PARK_Y); reset = 0;
    drive(0, PARK_X, PARK_Y);
    chk("rst2_count", int'(aliveCount), 32);
    chk("rst2_cleared", int'(fleetCleared), 0);
    xLaser = 10'd76; yLaser = 10'd48;
    drive(0, PARK_X, PARK_Y);
    chk("mid_kill", int'(killingAlien), 1);
    reset = 1;
    drive(0, PARK_X, PARK_Y); reset = 0;
    chk("midrst_kill", int'(killingAlien), 0);
    chk("midrst_count", int'(aliveCount), 32);

    for (int i = 0; i < 40000 && !m_landed; i++) drive(1, PARK_X, PARK_Y);
    drive(0, PARK_X, PARK_Y);
    drive(0, PARK_X, PARK_Y);
    chk("land_flag", int'(fleetLanded), 1);
    chk("land_fy", int'(fleetY), 344);
    chk("mdl_land_fy", m_fy, 344);
    saved = m_fx;
    repeat (8) drive(1, PARK_X, PARK_Y);
    drive(0, PARK_X, PARK_Y);
    chk("land_frozen", int'(fleetX), saved);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alien_fleet.md
# alien_fleet

Alien fleet controller for Space Invaders, and the far end of the laser interface. It keeps a ROWS x COLS grid of aliens with an alive mask and marches the grid across the screen and down toward the ship. It tests the player laser position against live aliens and returns `killingAlien` to the laser. It also drives the alien colour for the VGA pixel mux and flags when the fleet is cleared or has landed.

## Interface
Parameters:
- `ROWS`, 4, grid rows
- `COLS`, 8, grid columns
- `ALIEN_W`, 24, alien width in pixels
- `ALIEN_H`, 16, alien height in pixels
- `PITCH_X`, 32, horizontal cell pitch; power of two, greater than `ALIEN_W`
- `PITCH_Y`, 32, vertical cell pitch; power of two, greater than `ALIEN_H`
- `START_X`, 64, reset fleet origin x (top-left of cell [0][0])
- `START_Y`, 40, reset fleet origin y
- `STEP_X`, 2, pixels per horizontal move
- `STEP_Y`, 16, pixels per drop
- `MOVE_DIV`, 4, `enable` pulses per move
- `LAND_Y`, 440, landing line (SCREEN_HEIGHT - V_OFFSET - SHIP_HEIGHT)

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `enable`  in  1  game tick, one cycle per frame
- `xLaser`  in  10  laser centre x
- `yLaser`  in  10  laser centre y
- `hPos`  in  10  VGA pixel x
- `vPos`  in  10  VGA pixel y
- `killingAlien`  out  1  hit indication to the laser
- `colorAlien`  out  3  ALIEN or BACKGROUND colour code
- `aliveCount`  out  $clog2(ROWS*COLS+1)  number of live aliens
- `fleetX`  out  10  fleet origin x
- `fleetY`  out  10  fleet origin y
- `fleetCleared`  out  1  all aliens dead
- `fleetLanded`  out  1  lowest live row has reached `LAND_Y`

## Operation
- **Alive mask:** `ROWS*COLS` bits; bit index is r*COLS+c.
- **Cell lookup:** for a point (x,y), compute relX = x - fleetX and relY = y - fleetY.
  - col = relX/PITCH_X and row = relY/PITCH_Y, using shifts.
  - The point is inside an alien if relX%PITCH_X < ALIEN_W and relY%PITCH_Y < ALIEN_H, with col < COLS, row < ROWS, and no negative underflow.
- **Parked laser:** the position (SCREEN_WIDTH-1, SCREEN_HEIGHT-1) means no laser and never hits.
- **Hit detection:** evaluated every clk while state is MARCH or DROP and `killingAlien`=0.
  - On a hit, the next edge clears that alive bit, decrements `aliveCount` and sets `killingAlien`.
  - `killingAlien` holds until the edge ending the next cycle with `enable`=1, then clears.
  - This guarantees the laser samples the hit on its enable cycle.
  - No new detection happens while `killingAlien`=1.
- **Movement:** a direction register `dir` (right/left) and a move counter that counts `enable` pulses from 0 to MOVE_DIV-1. A move tick occurs when the counter wraps.
- **States:**
  - **MARCH:** on a move tick, compute the live column bounds from the mask.
    - Moving right: if fleetX + cmax*PITCH_X + ALIEN_W - 1 + STEP_X > SCREEN_WIDTH-1, go to DROP; otherwise fleetX += STEP_X.
    - Moving left: if fleetX + cmin*PITCH_X < STEP_X, go to DROP; otherwise fleetX -= STEP_X.
  - **DROP:** on the next move tick, fleetY += STEP_Y, flip `dir`, return to MARCH.
  - **HALT:** entered from any state once `aliveCount`=0 (`fleetCleared`=1) or fleetY + rmax*PITCH_Y + ALIEN_H - 1 >= LAND_Y (`fleetLanded`=1).
    - No movement and no hits in HALT.
    - Only `reset` exits HALT.
- **Simultaneous hit and move tick:** the hit uses the pre-move fleetX/fleetY; the bounds use the pre-clear mask.
- **Colour:** `colorAlien` = ALIEN if the (hPos,vPos) lookup lands inside a live alien, else BACKGROUND. It is updated every clk, independent of `enable`.

## Timing
- **Reset values:**
  - fleetX=START_X, fleetY=START_Y
  - `dir`=right, move counter=0, state=MARCH
  - mask all ones, `aliveCount`=ROWS*COLS
  - `killingAlien`=0, `colorAlien`=BACKGROUND
  - `fleetCleared`=0, `fleetLanded`=0
- **Latencies:**
  - `colorAlien`: 1 clk after (hPos,vPos).
  - `killingAlien`: 1 clk after the laser enters a live alien.
  - `fleetCleared` / `fleetLanded`: 1 clk after the condition becomes true.
- **Move cadence:** fleetX/fleetY update on the edge ending the enable cycle in which the counter wraps.
- **Reset mid-operation:** reset mid-operation drops `killingAlien` on the same edge and restores the full grid.

## Structure
- **Shared package `space_invaders_pkg`:**
  - colour codes (BACKGROUND=0, LASER=6, ALIEN=3)
  - SCREEN_WIDTH/HEIGHT, SHIP_WIDTH/HEIGHT, V_OFFSET
  - state enum (MARCH, DROP, HALT)
- **Sub-module `alien_grid_locator`:** combinational; takes point and fleet origin, returns row, col, inside.
  - Instantiated twice: once for the laser, once for the VGA pixel.
- **Bounds logic:** the live column/row bounds (cmin, cmax, rmax) are combinational priority encoders over the mask, inside `alien_fleet`.

## Test plan
- **Reset:** assert reset for 2 clk -> `aliveCount`=32, fleetX=64, fleetY=40, `killingAlien`=0, `colorAlien`=0.
- **March:** 4 enable pulses -> fleetX=66; 8 pulses -> fleetX=68.
- **Hit:** laser at (69,45) -> next clk `killingAlien`=1, bit 0 cleared, `aliveCount`=31.
  - `killingAlien` holds through one enable cycle, then clears.
  - A repeat at the same point gives no hit.
- **Misses:**
  - laser at (90,45) (horizontal gap) -> no hit
  - laser at (639,479) (parked) -> no hit
- **Right edge:** fleetX reaches 392 -> the next move tick enters DROP; the following move tick gives fleetY=56, `dir`=left, fleetX=392.
- **End conditions:**
  - Kill all 32 aliens -> `aliveCount`=0, `fleetCleared`=1, fleetX frozen.
  - Separately, a full fleet descending to fleetY=344 (lowest alien bottom row 455 >= 440) -> `fleetLanded`=1, state HALT.
